// File: rtl/map_port_arbiter.sv
// Wall-map read-port arbiter: the VGA renderer owns the port while i_busy is high,
// and the game-logic requesters share the remaining cycles round-robin with tagged read-back.
module map_port_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned COORD_W  = 6,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_busy,
  input  logic [COORD_W-1:0]         i_vga_x,
  input  logic [COORD_W-1:0]         i_vga_y,
  output logic                       o_vga_is_wall,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*COORD_W-1:0]   i_req_x,
  input  logic [N_REQ*COORD_W-1:0]   i_req_y,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_rvalid,
  output logic                       o_rdata,
  output logic [COORD_W-1:0]         o_map_x,
  output logic [COORD_W-1:0]         o_map_y,
  input  logic                       i_map_wall
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
    $error("map_port_arbiter: READ_LAT must be in 1..3");
  end
  if (N_REQ < 1) begin : g_bad_n_req
    $error("map_port_arbiter: N_REQ must be at least 1");
  end

  typedef struct packed {
    logic             vld;
    logic             vga;
    logic [PTR_W-1:0] id;
  } tag_t;

  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [COORD_W-1:0]  last_x_q;
  logic [COORD_W-1:0]  last_y_q;
  tag_t [READ_LAT-1:0] tag_q;
  tag_t                tag_out;
  logic                rd_fire;
  logic                vga_fire;
  logic                rdata_q;
  logic                vga_wall_q;

  function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    return PTR_W'((base + off) % N_REQ);
  endfunction

  // First requester at or after the pointer; nothing is granted while VGA owns the port.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (rst_n && !i_busy) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_any && i_req[wrap_idx(32'(ptr_q), i)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_idx(32'(ptr_q), i);
        end
      end
    end
  end

  always_comb begin
    o_gnt   = '0;
    o_map_x = last_x_q;
    o_map_y = last_y_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_any && gnt_idx == PTR_W'(k)) begin
        o_gnt[k] = 1'b1;
        o_map_x  = i_req_x[k*COORD_W +: COORD_W];
        o_map_y  = i_req_y[k*COORD_W +: COORD_W];
      end
    end
    if (!rst_n) begin
      o_map_x = '0;
      o_map_y = '0;
    end else if (i_busy) begin
      o_map_x = i_vga_x;
      o_map_y = i_vga_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      tag_q      <= '0;
      rdata_q    <= 1'b0;
      vga_wall_q <= 1'b0;
    end else begin
      if (gnt_any) ptr_q <= wrap_idx(32'(gnt_idx), 1);
      last_x_q   <= o_map_x;
      last_y_q   <= o_map_y;
      tag_q[0]   <= '{vld: i_busy | gnt_any, vga: i_busy, id: gnt_idx};
      for (int unsigned s = 1; s < READ_LAT; s++) tag_q[s] <= tag_q[s-1];
      rdata_q    <= o_rdata;
      vga_wall_q <= o_vga_is_wall;
    end
  end

  // The output tag lines up with the cycle in which i_map_wall is valid, so the data
  // is passed through in that cycle and captured only to hold it afterwards.
  assign tag_out  = tag_q[READ_LAT-1];
  assign rd_fire  = tag_out.vld & ~tag_out.vga;
  assign vga_fire = tag_out.vld & tag_out.vga;

  always_comb begin
    o_rvalid = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      o_rvalid[k] = rd_fire && (tag_out.id == PTR_W'(k));
    end
  end

  assign o_rdata       = rd_fire  ? i_map_wall : rdata_q;
  assign o_vga_is_wall = vga_fire ? i_map_wall : vga_wall_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter: one instance with READ_LAT=1 and one with READ_LAT=3,
// each fed by its own latency-matched wall-map model.
module tb_map_port_arbiter;

  localparam int N  = 4;
  localparam int CW = 6;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          busy  = 1'b0;
  logic [CW-1:0] vga_x = '0;
  logic [CW-1:0] vga_y = '0;
  logic [N-1:0]  req   = '0;
  logic [N*CW-1:0] req_x;
  logic [N*CW-1:0] req_y;

  logic          vga_wall1, vga_wall3, rdata1, rdata3, wall1, wall3;
  logic [N-1:0]  gnt1, gnt3, rvalid1, rvalid3;
  logic [CW-1:0] mx1, my1, mx3, my3;

  logic [CW-1:0] rx [N] = '{6'd1, 6'd2, 6'd10, 6'd4};
  logic [CW-1:0] ry [N] = '{6'd1, 6'd2, 6'd10, 6'd5};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  map_port_arbiter #(.N_REQ(N), .COORD_W(CW), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_busy(busy), .i_vga_x(vga_x), .i_vga_y(vga_y),
    .o_vga_is_wall(vga_wall1), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
    .o_gnt(gnt1), .o_rvalid(rvalid1), .o_rdata(rdata1),
    .o_map_x(mx1), .o_map_y(my1), .i_map_wall(wall1)
  );

  map_port_arbiter #(.N_REQ(N), .COORD_W(CW), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_busy(busy), .i_vga_x(vga_x), .i_vga_y(vga_y),
    .o_vga_is_wall(vga_wall3), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
    .o_gnt(gnt3), .o_rvalid(rvalid3), .o_rdata(rdata3),
    .o_map_x(mx3), .o_map_y(my3), .i_map_wall(wall3)
  );

  function automatic logic wall_of(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return ((int'(x) + int'(y)) % 3) == 2;
  endfunction

  logic [2*CW-1:0] a1 = '0;
  logic [2*CW-1:0] a3 [3] = '{default: '0};

  always @(posedge clk) begin
    a1    <= {mx1, my1};
    a3[0] <= {mx3, my3};
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end

  assign wall1 = wall_of(a1[2*CW-1:CW], a1[CW-1:0]);
  assign wall3 = wall_of(a3[2][2*CW-1:CW], a3[2][CW-1:0]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic [N-1:0] r, input logic [CW-1:0] vx,
                      input logic [CW-1:0] vy);
    @(negedge clk);
    busy  = b;
    req   = r;
    vga_x = vx;
    vga_y = vy;
    #1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      req_x[k*CW +: CW] = rx[k];
      req_y[k*CW +: CW] = ry[k];
    end

    #2 rst_n = 1'b0;
    step(0, '0, '0, '0);
    step(0, '0, '0, '0);
    check("rst_gnt", 32'(gnt1), 0);
    check("rst_rvalid", 32'(rvalid1), 0);
    check("rst_rdata", 32'(rdata1), 0);
    check("rst_vga_wall", 32'(vga_wall1), 0);
    check("rst_map_x", 32'(mx1), 0);
    check("rst_map_y", 32'(my1), 0);
    @(negedge clk) rst_n = 1'b1;

    // VGA priority with all requests pending
    step(1, 4'b1111, 6'd3, 6'd5);
    check("vga_gnt", 32'(gnt1), 0);
    check("vga_gnt3", 32'(gnt3), 0);
    check("vga_map_x", 32'(mx1), 3);
    check("vga_map_y", 32'(my1), 5);
    step(1, 4'b1111, 6'd3, 6'd5);
    check("vga_is_wall", 32'(vga_wall1), 1);
    check("vga_gnt_hold", 32'(gnt1), 0);

    // Round robin; grants begin on the busy 1->0 cycle
    for (int c = 0; c < 8; c++) begin
      step(0, 4'b1111, '0, '0);
      check("rr_gnt", 32'(gnt1), 32'(1) << (c % 4));
      check("rr_gnt3", 32'(gnt3), 32'(1) << (c % 4));
      check("rr_map_x", 32'(mx1), 32'(rx[c % 4]));
      check("rr_map_y", 32'(my1), 32'(ry[c % 4]));
      if (c == 0) begin
        check("rr_rvalid_first", 32'(rvalid1), 0);
      end else begin
        check("rr_rvalid", 32'(rvalid1), 32'(1) << ((c - 1) % 4));
        check("rr_rdata", 32'(rdata1), 32'(wall_of(rx[(c - 1) % 4], ry[(c - 1) % 4])));
      end
    end
    step(0, '0, '0, '0);
    check("idle_gnt", 32'(gnt1), 0);
    check("idle_rvalid", 32'(rvalid1), 4'b1000);
    check("idle_rdata", 32'(rdata1), 0);
    check("hold_map_x", 32'(mx1), 4);
    check("hold_map_y", 32'(my1), 5);

    // Pointer skip from pointer 1 with requests 0 and 3
    step(0, 4'b0001, '0, '0);
    check("skip_gnt0", 32'(gnt1), 4'b0001);
    step(0, 4'b1001, '0, '0);
    check("skip_gnt3", 32'(gnt1), 4'b1000);
    check("skip_rvalid0", 32'(rvalid1), 4'b0001);
    check("skip_rdata0", 32'(rdata1), 1);
    step(0, 4'b1001, '0, '0);
    check("skip_gnt_wrap", 32'(gnt1), 4'b0001);
    check("skip_rvalid3", 32'(rvalid1), 4'b1000);
    check("skip_rdata3", 32'(rdata1), 0);
    step(0, 4'b0011, '0, '0);
    check("skip_ptr_end", 32'(gnt1), 4'b0010);
    check("skip_rdata_wrap", 32'(rdata1), 1);
    step(0, '0, '0, '0);
    check("skip_rvalid1", 32'(rvalid1), 4'b0010);
    check("skip_rdata1", 32'(rdata1), 0);

    // Withdrawn request while busy
    step(1, 4'b0010, 6'd2, 6'd2);
    check("wd_gnt_a", 32'(gnt1), 0);
    check("wd_rvalid_a", 32'(rvalid1), 0);
    step(1, '0, 6'd2, 6'd2);
    check("wd_gnt_b", 32'(gnt1), 0);
    check("wd_rvalid_b", 32'(rvalid1), 0);
    for (int c = 0; c < 2; c++) begin
      step(0, '0, '0, '0);
      check("wd_gnt_c", 32'(gnt1), 0);
      check("wd_rvalid_c", 32'(rvalid1), 0);
    end

    // READ_LAT=3: logic read in flight across busy rising edge
    step(0, 4'b0100, '0, '0);
    check("edge_gnt", 32'(gnt3), 4'b0100);
    check("edge_map_x", 32'(mx3), 10);
    check("edge_map_y", 32'(my3), 10);
    step(1, '0, 6'd3, 6'd5);
    check("edge_gnt_busy", 32'(gnt3), 0);
    check("edge_rvalid_1", 32'(rvalid3), 0);
    check("edge_lat1_rvalid", 32'(rvalid1), 4'b0100);
    check("edge_lat1_rdata", 32'(rdata1), 1);
    step(1, '0, 6'd2, 6'd2);
    check("edge_rvalid_2", 32'(rvalid3), 0);
    step(1, '0, 6'd1, 6'd1);
    check("edge_rvalid_3", 32'(rvalid3), 4'b0100);
    check("edge_rdata_3", 32'(rdata3), 1);
    check("edge_vga_hold", 32'(vga_wall3), 0);
    step(0, '0, '0, '0);
    check("edge_rvalid_4", 32'(rvalid3), 0);
    check("edge_vga_a", 32'(vga_wall3), 1);
    step(0, '0, '0, '0);
    check("edge_vga_b", 32'(vga_wall3), 0);
    check("edge_rdata_hold", 32'(rdata3), 1);
    step(0, '0, '0, '0);
    check("edge_vga_c", 32'(vga_wall3), 1);

    // Reset with a READ_LAT=3 read in flight
    step(0, 4'b0001, '0, '0);
    check("rst2_gnt_pre", 32'(gnt3), 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    busy  = 1'b1;
    req   = 4'b0011;
    vga_x = 6'd7;
    vga_y = 6'd7;
    #1;
    check("rst2_gnt1", 32'(gnt1), 0);
    check("rst2_gnt3", 32'(gnt3), 0);
    check("rst2_map_x", 32'(mx3), 0);
    check("rst2_map_y", 32'(my3), 0);
    check("rst2_rvalid1", 32'(rvalid1), 0);
    check("rst2_rdata1", 32'(rdata1), 0);
    check("rst2_rdata3", 32'(rdata3), 0);
    check("rst2_vga_wall3", 32'(vga_wall3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    busy  = 1'b0;
    req   = '0;
    #1;
    check("rst2_rvalid_a", 32'(rvalid3), 0);
    for (int c = 0; c < 2; c++) begin
      step(0, '0, '0, '0);
      check("rst2_rvalid_b", 32'(rvalid3), 0);
    end
    step(0, 4'b0011, '0, '0);
    check("rst2_ptr1", 32'(gnt1), 4'b0001);
    check("rst2_ptr3", 32'(gnt3), 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
